// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - shared ISA constants and the decoded issue bundle type
package cpu_isa_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_MOVE  = 4'd2;
    localparam logic [3:0] OP_IMM   = 4'd3;
    localparam logic [3:0] OP_SETQ  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;

    localparam logic [2:0] REG_ADR  = 3'd4;
    localparam logic [2:0] REG_MATH = 3'd5;
    localparam logic [2:0] REG_CMP  = 3'd6;
    localparam logic [2:0] REG_CNT  = 3'd7;

    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS0_LSB = 4;
    localparam int RS1_LSB = 0;

    typedef struct packed {
        logic [3:0] readReg0;
        logic [3:0] readReg1;
        logic [3:0] writeReg;
        logic       write;
        logic       move;
        logic       immediate;
        logic       setQuarter;
        logic [1:0] regToMem;
        logic       memRead;
        logic       memWrite;
    } issueBundle_t;

endpackage

// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - pending-write scoreboard with RAW/WAW hazard check
module decode_scoreboard
    import cpu_isa_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0][2:0] rdIdx,
    input  logic [2:0]      rdEn,
    input  logic [2:0]      wrIdx,
    input  logic            wrEn,
    input  logic            setEn,
    input  logic            wbValid,
    input  logic [2:0]      wbReg,
    output logic            hazard
);

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] setMask;
    logic [NREGS-1:0] clrMask;

    // Hazard looks only at the registered bits; a retiring write frees its
    // consumer one cycle later.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rdEn[i] && sb[rdIdx[i]]) begin
                hazard = 1'b1;
            end
        end
        if (wrEn && sb[wrIdx]) begin
            hazard = 1'b1;
        end
    end

    assign setMask = setEn   ? (NREGS'(1) << wrIdx) : '0;
    assign clrMask = wbValid ? (NREGS'(1) << wbReg) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= (sb & ~clrMask) | setMask;
        end
    end

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - instruction decode and scoreboarded issue stage
module decode_issue
    import cpu_isa_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_readReg0,
    output logic [3:0]       out_readReg1,
    output logic [3:0]       out_writeReg,
    output logic             out_write,
    output logic             out_move,
    output logic             out_immediate,
    output logic             out_set_quarter,
    output logic [1:0]       out_regToMem,
    output logic             out_mem_read,
    output logic             out_mem_write,
    input  logic             wb_valid,
    input  logic [2:0]       wb_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]      op, rd, rs0, rs1;
    issueBundle_t    dec, bundleQ;
    logic [2:0][2:0] rdIdx;
    logic [2:0]      rdEn;
    logic            wrEn, bad, hazard, issue;

    assign op  = in_instr[OP_LSB  +: FIELD_W];
    assign rd  = in_instr[RD_LSB  +: FIELD_W];
    assign rs0 = in_instr[RS0_LSB +: FIELD_W];
    assign rs1 = in_instr[RS1_LSB +: FIELD_W];

    function automatic logic outOfRange(input logic [3:0] r);
        return int'(r) >= NREGS;
    endfunction

    // Read slots: 0 = rs0 (rd for STORE), 1 = rs1, 2 = adr.
    always_comb begin
        dec          = '0;
        dec.readReg0 = rs0;
        dec.readReg1 = rs1;
        dec.writeReg = rd;
        rdIdx[0]     = rs0[2:0];
        rdIdx[1]     = rs1[2:0];
        rdIdx[2]     = REG_ADR;
        rdEn         = '0;
        wrEn         = 1'b0;
        bad          = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ALU: begin
                rdEn      = 3'b011;
                wrEn      = 1'b1;
                dec.write = 1'b1;
                bad       = outOfRange(rd) || outOfRange(rs0) || outOfRange(rs1);
            end
            OP_MOVE: begin
                rdEn      = 3'b001;
                wrEn      = 1'b1;
                dec.write = 1'b1;
                dec.move  = 1'b1;
                bad       = outOfRange(rd) || outOfRange(rs0);
            end
            OP_IMM: begin
                wrEn          = 1'b1;
                dec.write     = 1'b1;
                dec.immediate = 1'b1;
                bad           = outOfRange(rd);
            end
            OP_SETQ: begin
                wrEn           = 1'b1;
                dec.write      = 1'b1;
                dec.immediate  = 1'b1;
                dec.setQuarter = 1'b1;
                dec.readReg1   = {2'b00, rs1[1:0]};
                bad            = outOfRange(rd);
            end
            OP_STORE: begin
                rdIdx[0]     = rd[2:0];
                rdEn         = 3'b101;
                dec.memWrite = 1'b1;
                dec.regToMem = rd[1:0];
                bad          = rd > 4'd3;
            end
            OP_LOAD: begin
                rdEn        = 3'b100;
                wrEn        = 1'b1;
                dec.write   = 1'b1;
                dec.memRead = 1'b1;
                bad         = outOfRange(rd);
            end
            default: bad = 1'b1;
        endcase
        // An illegal instruction travels as an all-zero NOP and touches no registers.
        if (bad) begin
            dec  = '0;
            rdEn = '0;
            wrEn = 1'b0;
        end
    end

    decode_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .rdIdx   (rdIdx),
        .rdEn    (rdEn),
        .wrIdx   (rd[2:0]),
        .wrEn    (wrEn),
        .setEn   (issue && wrEn),
        .wbValid (wb_valid),
        .wbReg   (wb_reg),
        .hazard  (hazard)
    );

    assign in_ready = !rst && !(in_valid && hazard) && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            bundleQ      <= '0;
            illegal      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (issue) begin
                out_valid <= 1'b1;
                bundleQ   <= dec;
                if (bad) begin
                    illegal <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && hazard && stall_cycles != CNT_MAX) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

    assign out_readReg0    = bundleQ.readReg0;
    assign out_readReg1    = bundleQ.readReg1;
    assign out_writeReg    = bundleQ.writeReg;
    assign out_write       = bundleQ.write;
    assign out_move        = bundleQ.move;
    assign out_immediate   = bundleQ.immediate;
    assign out_set_quarter = bundleQ.setQuarter;
    assign out_regToMem    = bundleQ.regToMem;
    assign out_mem_read    = bundleQ.memRead;
    assign out_mem_write   = bundleQ.memWrite;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - randomized self-checking bench for decode_issue
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, wb_valid;
    logic [15:0] in_instr;
    logic [2:0]  wb_reg;
    logic        in_ready, out_valid, out_write, out_move, out_immediate, out_set_quarter;
    logic        out_mem_read, out_mem_write, illegal;
    logic [3:0]  out_readReg0, out_readReg1, out_writeReg;
    logic [1:0]  out_regToMem;
    logic [15:0] stall_cycles;

    decode_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_readReg0(out_readReg0),
        .out_readReg1(out_readReg1), .out_writeReg(out_writeReg), .out_write(out_write),
        .out_move(out_move), .out_immediate(out_immediate), .out_set_quarter(out_set_quarter),
        .out_regToMem(out_regToMem), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .illegal(illegal), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] r0, r1, wr;
        logic       w, mv, im, sq;
        logic [1:0] rtm;
        logic       mr, mw;
        logic [7:0] readMask, writeMask;
        logic       bad;
    } ref_t;

    int         nChecks = 0;
    int         nFail   = 0;
    logic       mValid, mIll, expReady, obsReady;
    ref_t       mB;
    logic [7:0] mSb;
    int         mStall;

    wire [20:0] obsOut = {out_valid, out_readReg0, out_readReg1, out_writeReg, out_write, out_move,
                          out_immediate, out_set_quarter, out_regToMem, out_mem_read, out_mem_write};

    function automatic ref_t refDecode(input logic [15:0] ins);
        ref_t r;
        int op, rd, a, b, wr;
        int reads[$];
        op = int'(ins[15:12]); rd = int'(ins[11:8]); a = int'(ins[7:4]); b = int'(ins[3:0]);
        r = '0; wr = -1;
        r.r0 = 4'(a); r.r1 = 4'(b); r.wr = 4'(rd);
        case (op)
            0: ;
            1: begin reads = '{a, b}; wr = rd; r.w = 1; end
            2: begin reads = '{a}; wr = rd; r.w = 1; r.mv = 1; end
            3: begin wr = rd; r.w = 1; r.im = 1; end
            4: begin wr = rd; r.w = 1; r.im = 1; r.sq = 1; r.r1 = 4'(b % 4); end
            5: begin reads = '{rd, 4}; r.mw = 1; r.rtm = 2'(rd % 4); if (rd > 3) r.bad = 1; end
            6: begin reads = '{4}; wr = rd; r.w = 1; r.mr = 1; end
            default: r.bad = 1;
        endcase
        foreach (reads[i]) if (reads[i] >= 8) r.bad = 1;
        if (wr >= 8) r.bad = 1;
        if (r.bad) begin
            r = '0;
            r.bad = 1;
        end else begin
            foreach (reads[i]) r.readMask[reads[i]] = 1'b1;
            if (wr >= 0) r.writeMask[wr] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [20:0] expOut();
        return {mValid, mB.r0, mB.r1, mB.wr, mB.w, mB.mv, mB.im, mB.sq, mB.rtm, mB.mr, mB.mw};
    endfunction

    // Sample in_ready for the current inputs, advance the model one clock, wait for the edge.
    task automatic tick();
        ref_t d;
        logic haz, iss;
        #1;
        obsReady = in_ready;
        d   = refDecode(in_instr);
        haz = ((d.readMask | d.writeMask) & mSb) != 8'h00;
        if (rst) begin
            expReady = 1'b0;
            mValid = 0; mB = '0; mSb = '0; mIll = 0; mStall = 0;
        end else begin
            expReady = !(in_valid && haz) && (!mValid || out_ready);
            iss = in_valid && expReady;
            if (in_valid && haz && mStall < 65535) mStall++;
            if (wb_valid) mSb[wb_reg] = 1'b0;
            if (iss) begin
                mSb |= d.writeMask;
                mValid = 1'b1;
                mB = d;
                if (d.bad) mIll = 1'b1;
            end else if (out_ready) begin
                mValid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1; in_valid = 0; in_instr = '0; out_ready = 1; wb_valid = 0; wb_reg = '0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++;
        if (obsReady !== 1'b0) begin nFail++; $display("FAIL reset_in_ready got=%b want=0", obsReady); end
        nChecks++;
        if ({obsOut, illegal, stall_cycles} !== 38'd0)
            begin nFail++; $display("FAIL reset_state got=%h/%b/%0d want all zero", obsOut, illegal, stall_cycles); end
    endtask

    task automatic test_alu();
        doReset();
        in_valid = 1; in_instr = 16'h1123;
        tick();
        in_valid = 0;
        nChecks++;
        if ({out_valid, out_writeReg, out_readReg0, out_readReg1, out_write} !== {1'b1, 4'd1, 4'd2, 4'd3, 1'b1})
            begin nFail++; $display("FAIL alu_bundle got=%h want=%h", obsOut, expOut()); end
        tick();
        nChecks++;
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL alu_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        doReset();
        in_valid = 1; in_instr = 16'h1123;
        tick();
        in_instr = 16'h2010;
        for (int k = 1; k <= 3; k++) begin
            tick();
            nChecks++;
            if (obsReady !== 1'b0 || stall_cycles !== 16'(k))
                begin nFail++; $display("FAIL raw_stall got=%b/%0d want=0/%0d", obsReady, stall_cycles, k); end
        end
        wb_valid = 1; wb_reg = 3'd1;
        tick();
        wb_valid = 0;
        nChecks++;
        if (obsReady !== 1'b0) begin nFail++; $display("FAIL wb_no_bypass got=%b want=0", obsReady); end
        tick();
        in_valid = 0;
        nChecks++;
        if (obsReady !== 1'b1 || out_valid !== 1'b1 || out_move !== 1'b1 || out_writeReg !== 4'd0 || stall_cycles !== 16'd4)
            begin nFail++; $display("FAIL move_issue got=%b/%h/%0d want=1/%h/4", obsReady, obsOut, stall_cycles, expOut()); end
    endtask

    task automatic test_load();
        doReset();
        in_valid = 1; in_instr = 16'h3405;
        tick();
        in_instr = 16'h6200;
        tick(); tick();
        nChecks++;
        if (obsReady !== 1'b0) begin nFail++; $display("FAIL load_stall got=%b want=0", obsReady); end
        wb_valid = 1; wb_reg = 3'd4;
        tick();
        wb_valid = 0;
        tick();
        in_valid = 0;
        nChecks++;
        if ({out_valid, out_mem_read, out_writeReg, out_write} !== {1'b1, 1'b1, 4'd2, 1'b1})
            begin nFail++; $display("FAIL load_issue got=%h want=%h", obsOut, expOut()); end
    endtask

    task automatic test_store_illegal();
        doReset();
        in_valid = 1; in_instr = 16'h5300;
        tick();
        nChecks++;
        if ({out_valid, out_mem_write, out_regToMem, out_write, illegal} !== {1'b1, 1'b1, 2'd3, 1'b0, 1'b0})
            begin nFail++; $display("FAIL store_issue got=%h want=%h", obsOut, expOut()); end
        in_instr = 16'h5500;
        tick();
        in_instr = 16'h3100;
        in_valid = 0;
        nChecks++;
        if (illegal !== 1'b1 || obsOut !== 21'h100000)
            begin nFail++; $display("FAIL illegal_nop got=%b/%h want=1/100000", illegal, obsOut); end
        tick();
        nChecks++;
        if (illegal !== 1'b1) begin nFail++; $display("FAIL illegal_sticky got=%b want=1", illegal); end
    endtask

    task automatic test_hold();
        doReset();
        in_valid = 1; in_instr = 16'h3405; out_ready = 0;
        tick();
        in_instr = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            nChecks++;
            if (obsReady !== 1'b0 || obsOut !== {1'b1, 4'd0, 4'd5, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0})
                begin nFail++; $display("FAIL hold_stable got=%b/%h want=0/%h", obsReady, obsOut, expOut()); end
        end
        rst = 1;
        tick();
        rst = 0; out_ready = 1; in_instr = 16'h1440;
        nChecks++;
        if (out_valid !== 1'b0 || illegal !== 1'b0) begin nFail++; $display("FAIL reset_mid got=%b/%b want=0/0", out_valid, illegal); end
        tick();
        in_valid = 0;
        nChecks++;
        if (obsReady !== 1'b1) begin nFail++; $display("FAIL sb_cleared got=%b want=1", obsReady); end
    endtask

    task automatic test_random();
        int k;
        doReset();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 4) != 0;
            in_instr  = {4'($urandom_range(0, 8)),
                         (($urandom % 8) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                         (($urandom % 8) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                         (($urandom % 8) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7))};
            if (($urandom % 32) == 0) in_instr = 16'($urandom);
            out_ready = ($urandom % 4) != 0;
            wb_valid  = 0;
            if (mSb != 0 && ($urandom % 2) == 1) begin
                k = $urandom % 8;
                for (int j = 0; j < 8; j++) begin
                    if (!wb_valid && mSb[(k + j) % 8]) begin
                        wb_valid = 1;
                        wb_reg   = 3'((k + j) % 8);
                    end
                end
            end
            tick();
            nChecks++;
            if (obsReady !== expReady || obsOut !== expOut() || illegal !== mIll || stall_cycles !== 16'(mStall))
                begin
                    nFail++;
                    $display("FAIL random_step%0d got=%b/%h/%b/%0d want=%b/%h/%b/%0d", n,
                             obsReady, obsOut, illegal, stall_cycles, expReady, expOut(), mIll, mStall);
                end
        end
        in_valid = 0; wb_valid = 0;
    endtask

    task automatic test_saturate();
        doReset();
        in_valid = 1; in_instr = 16'h3100;
        tick();
        in_instr = 16'h2010;
        repeat (65534) @(posedge clk);
        #1;
        nChecks++;
        if (stall_cycles !== 16'd65534) begin nFail++; $display("FAIL stall_count got=%0d want=65534", stall_cycles); end
        repeat (4466) @(posedge clk);
        #1;
        nChecks++;
        if (stall_cycles !== 16'hFFFF) begin nFail++; $display("FAIL stall_saturate got=%h want=ffff", stall_cycles); end
        in_valid = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

    initial begin
        rst = 1; in_valid = 0; in_instr = '0; out_ready = 1; wb_valid = 0; wb_reg = '0;
        mValid = 0; mIll = 0; mB = '0; mSb = '0; mStall = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store_illegal();
        test_hold();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode stage between instruction fetch and the execute/register-file stage of the 16-bit pipelined CPU.
- Accepts one 16-bit instruction per cycle over a valid/ready handshake and decodes it into register-file controls: read selects, write target, move, immediate, set_quarter and regToMem.
- Holds a per-register pending-write scoreboard so a dependent instruction is never issued until the writeback stage has retired the producing write.

Parameters:
- NREGS, 8, architectural registers: reg0-reg3, adr(4), math(5), cmp(6), cnt(7).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  16  instruction: [15:12] op, [11:8] rd, [7:4] rs0/imm, [3:0] rs1/quarter.
- in_ready  out  1  decode can accept this cycle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_readReg0  out  4  rs0 field (imm for IMM/SETQ).
- out_readReg1  out  4  rs1 field (quarter index for SETQ).
- out_writeReg  out  4  rd.
- out_write, out_move, out_immediate, out_set_quarter  out  1 each  register-file controls.
- out_regToMem  out  2  rd[1:0] for STORE.
- out_mem_read, out_mem_write  out  1 each  LOAD/STORE strobes.
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_reg  in  3  register retired.
- illegal  out  1  sticky illegal-instruction flag.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Opcodes:
  - 0 NOP.
  - 1 ALU: reads rs0 and rs1, writes rd.
  - 2 MOVE: reads rs0, writes rd, move=1.
  - 3 IMM: writes rd, immediate=1, no reads.
  - 4 SETQ: writes rd, immediate=1, set_quarter=1, quarter=rs1[1:0].
  - 5 STORE: reads rd and adr, mem_write=1, regToMem=rd[1:0], write=0.
  - 6 LOAD: reads adr, writes rd, mem_read=1.
  - 7-15: illegal.
- Illegal conditions:
  - Opcode 7-15.
  - A written or read register index >= 8.
  - STORE with rd > 3.
- An illegal instruction issues as a NOP (all strobes 0) and sets illegal; only rst clears illegal.
- Scoreboard: sb[7:0], one bit per register.
  - hazard = any read register has sb=1, or the write target has sb=1 (RAW and WAW).
  - Hazard is evaluated on the registered sb, with no same-cycle bypass from wb.
- in_ready = !rst && !(in_valid && hazard) && (!out_valid || out_ready).
- Issue happens when in_valid && in_ready.
  - The output bundle register loads next edge; out_valid=1.
  - sb[rd] sets next edge if the instruction writes.
- Hold: if out_valid && !out_ready, the bundle and out_valid hold unchanged.
- Drain: when out_ready is 1 and no issue occurs, out_valid clears next edge.
- Writeback: wb_valid clears sb[wb_reg] next edge.
  - Issue set and wb clear of the same bit in one cycle cannot occur, because WAW stalls.
  - Clear and set of different bits in one cycle both apply.
  - wb_valid on a bit already 0 is ignored.
- Latency: one cycle from accepted instruction to out_valid. A stall released by wb allows issue on the cycle after sb clears.
- stall_cycles increments each cycle that in_valid && hazard, and saturates at all-ones.
- Reset: out_valid=0, all out_* fields=0, sb=0, illegal=0, stall_cycles=0, in_ready=0 during rst.
  - Reset mid-operation discards the held bundle and all pending bits.
  - The pipeline owner is required to reset writeback concurrently.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode constants OP_NOP..OP_LOAD;
  - register index constants REG_ADR=4, REG_MATH=5, REG_CMP=6, REG_CNT=7;
  - field-position constants.
- One sub-module, decode_scoreboard: the sb register, set/clear logic and the hazard check for up to three read indices plus one write index.

Test Plan:
- Reset, then in_valid with 0x1123 (ALU r1<-r2,r3), out_ready=1 → next cycle out_valid=1, out_writeReg=1, out_readReg0=2, out_readReg1=3, out_write=1; sb=0x02.
- 0x1123 then 0x2010 (MOVE r0<-r1) back-to-back → in_ready=0 while sb[1]=1, stall_cycles counts 1 per cycle. wb_valid with wb_reg=1 → MOVE issues the following cycle with out_move=1.
- 0x3405 (IMM adr<-5) then 0x6200 (LOAD r2) → LOAD stalls on adr until wb_reg=4, then issues with out_mem_read=1.
- 0x5300 (STORE r3) with sb=0 → out_mem_write=1, out_regToMem=3, out_write=0. Then 0x5500 → illegal=1 and a NOP bundle issues.
- out_ready=0 for 3 cycles with a bundle held → bundle stable, in_ready=0. Assert rst → out_valid=0, sb=0, illegal=0 next edge.
- Force 70000 stall cycles → stall_cycles saturates at 0xFFFF.
